// File: rtl/nlb_c1tx_issue_if.sv
// -----------------------------------------------------------------------------
// nlb_c1tx_issue_if
// Bundles the two bus-facing sides of the C1 Tx issue stage:
//   - the request FIFO read side: show-ahead head valid/control at T0, the
//     pop strobe, and the data word that follows two clocks after the pop;
//   - the CCI C1 Tx request channel plus its almost-full and write-response
//     inputs.
// Modports:
//   master : view of the issue stage (drives pop strobe and C1 Tx request)
//   slave  : view of the environment (FIFO + channel)
// -----------------------------------------------------------------------------
interface nlb_c1tx_issue_if #(
    parameter int DATA_WIDTH = 556,
    parameter int HDR_WIDTH  = 44,
    parameter int CTL_WIDTH  = 1
);
    // FIFO read side
    logic                             fifo_dout_v;
    logic [CTL_WIDTH-1:0]             fifo_ctlout;
    logic [DATA_WIDTH-1:0]            fifo_dout;
    logic                             fifo_rdack;
    // C1 Tx channel side
    logic                             c1TxAlmFull;
    logic                             c1Rx_rspValid;
    logic                             c1Tx_valid;
    logic [HDR_WIDTH-1:0]             c1Tx_hdr;
    logic [DATA_WIDTH-HDR_WIDTH-1:0]  c1Tx_data;

    modport master (
        input  fifo_dout_v, fifo_ctlout, fifo_dout, c1TxAlmFull, c1Rx_rspValid,
        output fifo_rdack, c1Tx_valid, c1Tx_hdr, c1Tx_data
    );

    modport slave (
        output fifo_dout_v, fifo_ctlout, fifo_dout, c1TxAlmFull, c1Rx_rspValid,
        input  fifo_rdack, c1Tx_valid, c1Tx_hdr, c1Tx_data
    );
endinterface

// File: rtl/nlb_c1tx_issue.sv
// -----------------------------------------------------------------------------
// nlb_c1tx_issue
// Pops write requests from the show-ahead C1 Tx request FIFO, re-aligns each
// pop with the FIFO data word that arrives two clocks later, and drives one
// registered write request per popped entry onto the CCI C1 Tx channel.
// Pops are held off by channel almost-full, by the outstanding-write cap, and
// by write fences (a fence waits until every earlier write is acknowledged).
// Ports:
//   Clk, Resetb     clock, asynchronous active-low reset
//   issue_en        permits new pops; entries already in flight always drain
//   bus (master)    FIFO read side and C1 Tx channel, see nlb_c1tx_issue_if
//   outstanding     writes issued and not yet acknowledged
//   num_issued      total lines issued (wraps)
//   fence_wait      high while holding a fence for outstanding writes
//   rsp_underflow   sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module nlb_c1tx_issue #(
    parameter int DATA_WIDTH      = 556,
    parameter int HDR_WIDTH       = 44,
    parameter int CTL_WIDTH       = 1,
    parameter int MAX_OUTSTANDING = 64,
    parameter int OCNT_WIDTH      = 7
) (
    input  logic                   Clk,
    input  logic                   Resetb,
    input  logic                   issue_en,
    nlb_c1tx_issue_if.master       bus,
    output logic [OCNT_WIDTH-1:0]  outstanding,
    output logic [31:0]            num_issued,
    output logic                   fence_wait,
    output logic                   rsp_underflow
);

    localparam logic [OCNT_WIDTH-1:0] MAX_CNT   = OCNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [OCNT_WIDTH-1:0] OCNT_ZERO = {OCNT_WIDTH{1'b0}};
    localparam logic [OCNT_WIDTH-1:0] OCNT_ONE  = {{(OCNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_ISSUE      = 1'b0,
        ST_FENCE_WAIT = 1'b1
    } state_t;

    state_t                          state_r;
    state_t                          state_nxt_s;
    logic                            pop_s;
    logic                            fence_head_s;
    logic                            below_cap_s;
    logic                            p1_v_r;
    logic                            p2_v_r;
    logic                            tx_valid_r;
    logic [HDR_WIDTH-1:0]            tx_hdr_r;
    logic [DATA_WIDTH-HDR_WIDTH-1:0] tx_data_r;
    logic [OCNT_WIDTH-1:0]           ocnt_r;
    logic [OCNT_WIDTH-1:0]           ocnt_nxt_s;
    logic                            underflow_r;
    logic                            underflow_nxt_s;
    logic [31:0]                     num_issued_r;
    logic                            fence_wait_r;

    // A fence only matters once it is actually at the FIFO head.
    assign fence_head_s = bus.fifo_dout_v & bus.fifo_ctlout[0];
    assign below_cap_s  = (ocnt_r < MAX_CNT);

    // Next-state and pop decision; Resetb gates the pop so the strobe is low
    // throughout reset even though it is combinational.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                if (fence_head_s && (ocnt_r != OCNT_ZERO)) begin
                    state_nxt_s = ST_FENCE_WAIT;
                end else begin
                    pop_s = Resetb & issue_en & bus.fifo_dout_v &
                            ~bus.c1TxAlmFull & below_cap_s;
                end
            end
            ST_FENCE_WAIT: begin
                if (ocnt_r == OCNT_ZERO) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_FENCE_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_ISSUE;
            end
        endcase
    end

    // Outstanding counter: counted at pop time so in-flight entries are
    // included; a response with nothing outstanding holds zero and flags.
    always_comb begin
        ocnt_nxt_s      = ocnt_r;
        underflow_nxt_s = underflow_r;
        case ({pop_s, bus.c1Rx_rspValid})
            2'b10: begin
                ocnt_nxt_s = ocnt_r + OCNT_ONE;
            end
            2'b01: begin
                if (ocnt_r == OCNT_ZERO) begin
                    underflow_nxt_s = 1'b1;
                end else begin
                    ocnt_nxt_s = ocnt_r - OCNT_ONE;
                end
            end
            default: begin
                ocnt_nxt_s = ocnt_r;
            end
        endcase
    end

    // State register, fence status and counters.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            state_r      <= ST_ISSUE;
            fence_wait_r <= 1'b0;
            ocnt_r       <= OCNT_ZERO;
            underflow_r  <= 1'b0;
            num_issued_r <= 32'd0;
        end else begin
            state_r      <= state_nxt_s;
            fence_wait_r <= (state_nxt_s == ST_FENCE_WAIT);
            ocnt_r       <= ocnt_nxt_s;
            underflow_r  <= underflow_nxt_s;
            if (tx_valid_r) begin
                num_issued_r <= num_issued_r + 32'd1;
            end
        end
    end

    // Two-stage valid pipeline tracking the FIFO's two-clock data latency,
    // then the registered request valid.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            p1_v_r     <= 1'b0;
            p2_v_r     <= 1'b0;
            tx_valid_r <= 1'b0;
        end else begin
            p1_v_r     <= pop_s;
            p2_v_r     <= p1_v_r;
            tx_valid_r <= p2_v_r;
        end
    end

    // Request header/payload capture at T2; meaningless while valid is low,
    // so no reset is needed.
    always_ff @(posedge Clk) begin
        if (p2_v_r) begin
            tx_hdr_r  <= bus.fifo_dout[DATA_WIDTH-1 -: HDR_WIDTH];
            tx_data_r <= bus.fifo_dout[DATA_WIDTH-HDR_WIDTH-1:0];
        end
    end

    assign bus.fifo_rdack = pop_s;
    assign bus.c1Tx_valid = tx_valid_r;
    assign bus.c1Tx_hdr   = tx_hdr_r;
    assign bus.c1Tx_data  = tx_data_r;
    assign outstanding    = ocnt_r;
    assign num_issued     = num_issued_r;
    assign fence_wait     = fence_wait_r;
    assign rsp_underflow  = underflow_r;

endmodule
